line_clear_ctrl: RTL

Sequencer for the row-shift datapath. After each piece lands, it repeatedly scans the settled board for full rows and commands one single-row shift per full row until none remain. It then scores the drop and updates the line count and difficulty level. It sits between the game FSM (start/done handshake) and the board shift register (clear_en/clear_row).

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/full_row_finder.sv | 23 ++
 rtl/line_clear_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Board geometry, FSM encoding and scoring table shared by the line-clear sequencer and its helpers.
package tetris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef logic [COLS-1:0] row_t;
    typedef row_t [ROWS-1:0] board_t;

    localparam row_t FULL_ROW = '1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SHIFT,
        SETTLE,
        SCORE,
        DONE
    } state_t;

    // Points per drop, indexed by lines cleared (0..4); widest entry fits in 11 bits.
    localparam logic [10:0] POINTS [0:4] = '{11'd0, 11'd40, 11'd100, 11'd300, 11'd1200};

endpackage

// File: rtl/full_row_finder.sv
// Combinational search for the bottom-most full row; zero latency.
// Backpressure: none, pure function of the board.
module full_row_finder
    import tetris_pkg::*;
(
    input  board_t      board,
    output logic        found,
    output logic [4:0]  idx
);

    // Ascending scan so the last match, the highest index, wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (board[r] == FULL_ROW) begin
                found = 1'b1;
                idx   = 5'(r);
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Clears full rows one at a time after each landed piece, then scores the drop; 3 cycles per row plus 3.
// Backpressure: start is ignored while busy; done pulses once when the drop is fully processed.
module line_clear_ctrl #(
    parameter int ROWS            = tetris_pkg::ROWS,
    parameter int COLS            = tetris_pkg::COLS,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      new_game,
    input  logic [ROWS-1:0][COLS-1:0] board,
    output logic                      clear_en,
    output logic [4:0]                clear_row,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                lines_drop,
    output logic [15:0]               total_lines,
    output logic [3:0]                level,
    output logic [19:0]               score
);

    localparam int              SUB_W     = (LINES_PER_LEVEL > 1) ? $clog2(LINES_PER_LEVEL) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(LINES_PER_LEVEL - 1);
    localparam logic [3:0]      LEVEL_MAX = 4'(MAX_LEVEL);

    tetris_pkg::state_t state;
    tetris_pkg::state_t stateNext;

    logic             rowFound;
    logic [4:0]       rowIdx;
    logic [SUB_W-1:0] subCnt;
    logic [10:0]      dropPoints;
    logic [4:0]       levelMult;
    logic [14:0]      dropScore;
    logic [20:0]      scoreSum;

    // Geometry must match the package board_t seen by the finder.
    full_row_finder uFinder (
        .board (board),
        .found (rowFound),
        .idx   (rowIdx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= tetris_pkg::IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        clear_en  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            tetris_pkg::IDLE: begin
                busy = 1'b0;
                if (start) stateNext = tetris_pkg::SCAN;
            end
            tetris_pkg::SCAN:   stateNext = rowFound ? tetris_pkg::SHIFT : tetris_pkg::SCORE;
            tetris_pkg::SHIFT: begin
                clear_en  = 1'b1;
                stateNext = tetris_pkg::SETTLE;
            end
            tetris_pkg::SETTLE: stateNext = tetris_pkg::SCAN;
            tetris_pkg::SCORE:  stateNext = tetris_pkg::DONE;
            tetris_pkg::DONE: begin
                done      = 1'b1;
                stateNext = tetris_pkg::IDLE;
            end
            default: begin
                busy      = 1'b0;
                stateNext = tetris_pkg::IDLE;
            end
        endcase
    end

    // Level here already includes this drop's increments, since SCORE follows the last SHIFT.
    always_comb begin
        dropPoints = (lines_drop > 3'd4) ? tetris_pkg::POINTS[4] : tetris_pkg::POINTS[lines_drop];
        levelMult  = {1'b0, level} + 5'd1;
        dropScore  = {4'd0, dropPoints} * {10'd0, levelMult};
        scoreSum   = {1'b0, score} + {6'd0, dropScore};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_row   <= '0;
            lines_drop  <= '0;
            total_lines <= '0;
            level       <= '0;
            score       <= '0;
            subCnt      <= '0;
        end else begin
            case (state)
                tetris_pkg::IDLE: begin
                    if (start) begin
                        lines_drop <= '0;
                    end else if (new_game) begin
                        lines_drop  <= '0;
                        total_lines <= '0;
                        level       <= '0;
                        score       <= '0;
                        subCnt      <= '0;
                    end
                end
                tetris_pkg::SCAN: begin
                    if (rowFound) clear_row <= rowIdx;
                end
                tetris_pkg::SHIFT: begin
                    if (lines_drop < 3'd4)         lines_drop  <= lines_drop + 3'd1;
                    if (total_lines != 16'hFFFF)   total_lines <= total_lines + 16'd1;
                    if (subCnt == SUB_LAST) begin
                        subCnt <= '0;
                        if (level != LEVEL_MAX) level <= level + 4'd1;
                    end else begin
                        subCnt <= subCnt + 1'b1;
                    end
                end
                tetris_pkg::SCORE: begin
                    score <= scoreSum[20] ? 20'hFFFFF : scoreSum[19:0];
                end
                default: ;
            endcase
        end
    end

endmodule
